// File: rtl/comparator_4bit_sync.sv
// comparator_4bit_sync
//   Registered magnitude comparator for two WIDTH-bit operands. Each accepted
//   input produces one-hot gt/eq/lt flags and the larger/smaller operand,
//   all registered, exactly one clock later. The compare is unsigned or
//   two's-complement, chosen per transaction by signed_mode.
//
//   Optional build macro: COMPARATOR_STATS_EN
//     When defined, adds the saturating result counters cnt_gt, cnt_eq and
//     cnt_lt (CNT_W bits each). When undefined, those ports do not exist.
//
// Parameters
//   WIDTH  operand width, 2..32 (default 4)
//   CNT_W  statistics counter width (default 16, used with COMPARATOR_STATS_EN)
//
// Ports
//   clk          system clock, rising-edge active
//   rst          synchronous reset, active-high, has priority over in_valid
//   in_valid     a/b/signed_mode are valid this cycle
//   a, b         operands
//   signed_mode  0 = unsigned compare, 1 = two's-complement compare
//   out_valid    results were updated from an input accepted on the last edge
//   gt, eq, lt   one-hot compare flags (all 0 after reset until the first input)
//   max_out      larger operand (a when equal)
//   min_out      smaller operand (b when equal)
//   cnt_gt/eq/lt saturating per-result counters (COMPARATOR_STATS_EN only)

module comparator_4bit_sync #(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             signed_mode,
  output logic             out_valid,
  output logic             gt,
  output logic             eq,
  output logic             lt,
  output logic [WIDTH-1:0] max_out,
  output logic [WIDTH-1:0] min_out
`ifdef COMPARATOR_STATS_EN
  ,
  output logic [CNT_W-1:0] cnt_gt,
  output logic [CNT_W-1:0] cnt_eq,
  output logic [CNT_W-1:0] cnt_lt
`endif
);

  // Elaboration-time guards on the parameter ranges.
  if (WIDTH < 2 || WIDTH > 32) begin : g_bad_width
    $error("comparator_4bit_sync: WIDTH must be in 2..32");
  end
  if (CNT_W < 1) begin : g_bad_cnt_w
    $error("comparator_4bit_sync: CNT_W must be at least 1");
  end

  // Compare keys: inverting the sign bit in signed mode maps two's-complement
  // order onto unsigned order, so one unsigned comparator serves both modes.
  logic [WIDTH-1:0] a_key;
  logic [WIDTH-1:0] b_key;
  logic             a_gt_b;
  logic             a_eq_b;
  logic             a_lt_b;
  logic [WIDTH-1:0] max_next;
  logic [WIDTH-1:0] min_next;

  always_comb begin
    a_key  = {a[WIDTH-1] ^ signed_mode, a[WIDTH-2:0]};
    b_key  = {b[WIDTH-1] ^ signed_mode, b[WIDTH-2:0]};
    a_eq_b = (a == b);
    a_gt_b = (a_key > b_key);
    a_lt_b = !a_gt_b && !a_eq_b;
    // Equality selects a for max and b for min; values are identical anyway.
    max_next = a_lt_b ? b : a;
    min_next = a_lt_b ? a : b;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      gt        <= 1'b0;
      eq        <= 1'b0;
      lt        <= 1'b0;
      max_out   <= '0;
      min_out   <= '0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        gt      <= a_gt_b;
        eq      <= a_eq_b;
        lt      <= a_lt_b;
        max_out <= max_next;
        min_out <= min_next;
      end
    end
  end

`ifdef COMPARATOR_STATS_EN
  // Counters advance on the same edge as the flags and stick at all-ones.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_gt <= '0;
      cnt_eq <= '0;
      cnt_lt <= '0;
    end else if (in_valid) begin
      if (a_gt_b && (cnt_gt != '1)) cnt_gt <= cnt_gt + CNT_W'(1);
      if (a_eq_b && (cnt_eq != '1)) cnt_eq <= cnt_eq + CNT_W'(1);
      if (a_lt_b && (cnt_lt != '1)) cnt_lt <= cnt_lt + CNT_W'(1);
    end
  end
`endif

endmodule

// File: tb/tb_comparator_4bit_sync.sv
module tb_comparator_4bit_sync;

  localparam int unsigned W  = 4;
  localparam int unsigned CW = 2;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         signed_mode;
  logic         out_valid;
  logic         gt;
  logic         eq;
  logic         lt;
  logic [W-1:0] max_out;
  logic [W-1:0] min_out;
`ifdef COMPARATOR_STATS_EN
  logic [CW-1:0] cnt_gt;
  logic [CW-1:0] cnt_eq;
  logic [CW-1:0] cnt_lt;
`endif

  int unsigned n_vec  = 0;
  int unsigned n_miss = 0;

  comparator_4bit_sync #(.WIDTH(W), .CNT_W(CW)) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .a           (a),
    .b           (b),
    .signed_mode (signed_mode),
    .out_valid   (out_valid),
    .gt          (gt),
    .eq          (eq),
    .lt          (lt),
    .max_out     (max_out),
    .min_out     (min_out)
`ifdef COMPARATOR_STATS_EN
    ,
    .cnt_gt      (cnt_gt),
    .cnt_eq      (cnt_eq),
    .cnt_lt      (cnt_lt)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Checks the full registered result against hand-computed values.
  task automatic check_res(input string tag, input logic ov, input logic [2:0] gel,
                           input logic [W-1:0] mx, input logic [W-1:0] mn);
    check({tag, ".out_valid"}, 32'(out_valid), 32'(ov));
    check({tag, ".gel"}, 32'({gt, eq, lt}), 32'(gel));
    check({tag, ".max"}, 32'(max_out), 32'(mx));
    check({tag, ".min"}, 32'(min_out), 32'(mn));
  endtask

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         s;
    logic [2:0]   gel;  // {gt, eq, lt}
    logic [W-1:0] mx;
    logic [W-1:0] mn;
  } vec_t;

  // Hand-computed expected results.
  vec_t vecs[10] = '{
    '{4'b1010, 4'b0101, 1'b0, 3'b100, 4'b1010, 4'b0101},  // 10 > 5
    '{4'b1001, 4'b1001, 1'b0, 3'b010, 4'b1001, 4'b1001},  // equal
    '{4'b0011, 4'b1010, 1'b0, 3'b001, 4'b1010, 4'b0011},  // 3 < 10
    '{4'b0000, 4'b1111, 1'b0, 3'b001, 4'b1111, 4'b0000},  // 0 < 15
    '{4'b0000, 4'b1111, 1'b1, 3'b100, 4'b0000, 4'b1111},  // 0 > -1
    '{4'b1111, 4'b0000, 1'b0, 3'b100, 4'b1111, 4'b0000},  // 15 > 0
    '{4'b1111, 4'b0000, 1'b1, 3'b001, 4'b0000, 4'b1111},  // -1 < 0
    '{4'b1000, 4'b0111, 1'b1, 3'b001, 4'b0111, 4'b1000},  // -8 < 7
    '{4'b0111, 4'b1000, 1'b0, 3'b001, 4'b1000, 4'b0111},  // 7 < 8
    '{4'b1110, 4'b1101, 1'b1, 3'b100, 4'b1110, 4'b1101}   // -2 > -3
  };

  task automatic drive(input logic v, input logic [W-1:0] av, input logic [W-1:0] bv,
                       input logic s);
    @(negedge clk);
    in_valid    = v;
    a           = av;
    b           = bv;
    signed_mode = s;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; a = '0; b = '0; signed_mode = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_res("reset", 1'b0, 3'b000, 4'h0, 4'h0);
`ifdef COMPARATOR_STATS_EN
    check("reset.cnt", 32'({cnt_gt, cnt_eq, cnt_lt}), 32'h0);
`endif
    @(negedge clk);
    rst = 1'b0;

    // Back-to-back valid inputs: in_valid stays high through the whole table.
    foreach (vecs[i]) begin
      drive(1'b1, vecs[i].a, vecs[i].b, vecs[i].s);
      check_res($sformatf("vec%0d", i), 1'b1, vecs[i].gel, vecs[i].mx, vecs[i].mn);
    end

    // Idle cycles: out_valid drops, results hold the last (-2 vs -3) values.
    drive(1'b0, 4'b0000, 4'b0101, 1'b0);
    check_res("hold1", 1'b0, 3'b100, 4'b1110, 4'b1101);
    drive(1'b0, 4'b0011, 4'b0011, 1'b1);
    check_res("hold2", 1'b0, 3'b100, 4'b1110, 4'b1101);

    // Reset wins over a simultaneous valid input.
    @(negedge clk);
    rst = 1'b1;
    drive(1'b1, 4'b1111, 4'b0000, 1'b0);
    check_res("rst_prio", 1'b0, 3'b000, 4'h0, 4'h0);
`ifdef COMPARATOR_STATS_EN
    check("rst_prio.cnt", 32'({cnt_gt, cnt_eq, cnt_lt}), 32'h0);
`endif
    @(negedge clk);
    rst = 1'b0;
    drive(1'b1, 4'b0101, 4'b0101, 1'b1);
    check_res("post_rst", 1'b1, 3'b010, 4'b0101, 4'b0101);
`ifdef COMPARATOR_STATS_EN
    check("post_rst.cnt_eq", 32'(cnt_eq), 32'd1);
`endif

    // Five greater-than results; a 2-bit counter saturates at 3.
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 4'(i + 2), 4'b0001, 1'b0);
      check_res($sformatf("gt_run%0d", i), 1'b1, 3'b100, 4'(i + 2), 4'b0001);
`ifdef COMPARATOR_STATS_EN
      check($sformatf("gt_run%0d.cnt_gt", i), 32'(cnt_gt), (i < 3) ? 32'(i + 1) : 32'd3);
`endif
    end
`ifdef COMPARATOR_STATS_EN
    check("sat.cnt_eq", 32'(cnt_eq), 32'd1);
    check("sat.cnt_lt", 32'(cnt_lt), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    drive(1'b0, 4'b0000, 4'b0000, 1'b0);
    check("final_rst.cnt", 32'({cnt_gt, cnt_eq, cnt_lt}), 32'h0);
    rst = 1'b0;
`endif

    in_valid = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/comparator_4bit_sync.md
Name: comparator_4bit_sync

Overview:
Registered magnitude comparator for two WIDTH-bit operands (default 4). It produces one-hot greater/equal/less flags, plus the max and min operand values, one clock after a valid input. It supports unsigned and two's-complement compare, selected per transaction. It is a leaf datapath block feeding control logic that needs registered compare results.

Parameters:
WIDTH, 4, operand width in bits (legal range 2..32)
CNT_W, 16, width of the statistics counters (used only with COMPARATOR_STATS_EN)

Ports:
clk  input  1  system clock, all state updates on the rising edge
rst  input  1  synchronous reset, active-high
in_valid  input  1  a/b/signed_mode are valid this cycle
a  input  WIDTH  operand A
b  input  WIDTH  operand B
signed_mode  input  1  0 = unsigned compare, 1 = two's-complement compare
out_valid  output  1  result registers updated from an accepted input on the previous edge
gt  output  1  A > B
eq  output  1  A == B
lt  output  1  A < B
max_out  output  WIDTH  larger operand (A when equal)
min_out  output  WIDTH  smaller operand (B when equal)

Behaviour:
- Interface: one clock (clk); reset (rst) is synchronous and active-high.
- Reset: when rst=1 at a rising edge, out_valid, gt, eq, lt = 0 and max_out, min_out = 0.
- rst has priority over in_valid in the same cycle.
- Accept: when in_valid=1 and rst=0 at a rising edge, compute on a, b, signed_mode and register the results. Latency is exactly 1 cycle. There is no backpressure; every valid cycle is accepted, so throughput is 1 per clock.
- out_valid is 1 in the cycle after an accepted input, else 0.
- Hold: when in_valid=0, gt/eq/lt/max_out/min_out keep their last values and only out_valid drops to 0.
- Flags: after the first accepted input, exactly one of gt/eq/lt is 1 (one-hot). Before it, or after reset, all three are 0.
- Unsigned mode: plain magnitude compare of a and b.
- Signed mode: bit WIDTH-1 is the sign bit. Example: 1111 (-1) < 0000 (0), and 1000 (-8) is the minimum value.
- eq is independent of signed_mode.
- max_out/min_out follow the same mode as the flags. On equality, max_out = a and min_out = b (both are identical values).
- Implementation is purely synchronous: no latches, no combinational path from inputs to outputs.

Optional Feature:
Macro COMPARATOR_STATS_EN.
- Defined: adds three outputs cnt_gt, cnt_eq, cnt_lt (each CNT_W bits).
  - Each counter increments by 1 on every accepted input whose result is gt, eq or lt respectively.
  - Counters update in the same edge as the flag registers.
  - Counters saturate at all-ones and do not wrap.
  - Counters clear to 0 on rst.
- Not defined: these ports and their logic are absent; all other behaviour is identical.

Test Plan:
- Reset, then unsigned a=1010, b=0101 with in_valid=1 -> next cycle out_valid=1, gt=1, eq=0, lt=0, max_out=1010, min_out=0101.
- Unsigned a=1001, b=1001 -> eq=1, gt=lt=0, max_out=min_out=1001. Then a=0011, b=1010 -> lt=1, max_out=1010, min_out=0011.
- a=0000, b=1111: signed_mode=0 -> lt=1; signed_mode=1 -> gt=1, max_out=0000, min_out=1111. Then a=1111, b=0000: unsigned -> gt=1; signed -> lt=1.
- Back-to-back valid inputs over 5 consecutive cycles -> 5 consecutive out_valid pulses with matching results. Then in_valid=0 -> out_valid=0 and flags/max/min hold their last values.
- Assert rst in the same cycle as in_valid=1 with a=1111, b=0000 -> next cycle all outputs 0, out_valid=0. Release rst and apply a valid input -> normal result after 1 cycle.
- With COMPARATOR_STATS_EN and CNT_W=2: apply 5 gt-producing inputs -> cnt_gt=3 (saturated), cnt_eq=cnt_lt=0. Then rst -> all counters 0.
